// File: rtl/hamming_pkg.sv
// Shared widths, error classes and the syndrome classifier for the Hamming
// decoder error monitor.
package hamming_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int SYN_W  = 4;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CORR   = 2'd1,
    ERR_UNCORR = 2'd2
  } err_class_t;

  // A non-zero syndrome that names a codeword bit was a single-bit error, and
  // the decoder has already fixed it; anything beyond the codeword is uncorrectable.
  function automatic err_class_t classify(input logic [SYN_W-1:0] syn);
    if (syn == '0)
      return ERR_NONE;
    else if (syn <= SYN_W'(CODE_W))
      return ERR_CORR;
    else
      return ERR_UNCORR;
  endfunction

endpackage

// File: rtl/hamming_sync_fifo.sv
// Small synchronous FIFO with the head entry always visible on its output.
module hamming_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // The extra pointer bit tells a full buffer apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_err_monitor.sv
// Classifies decoded bytes by syndrome, buffers them for a valid/ready consumer,
// and tracks saturating error counts plus a windowed error-rate alarm.
module hamming_err_monitor
  import hamming_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int WINDOW       = 256,
  parameter int ALARM_THRESH = 8,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SYN_W-1:0]  in_syndrome,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output err_class_t        out_err,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count,
  output logic              alarm
);

  localparam int FIFO_W = DATA_W + 2;
  localparam int WIN_W  = $clog2(WINDOW + 1);

  logic              full;
  logic              empty;
  logic              accept;
  logic              is_err;
  err_class_t        in_class;
  logic [FIFO_W-1:0] head;
  logic [WIN_W-1:0]  win_words;
  logic [WIN_W-1:0]  win_errs;
  logic [WIN_W-1:0]  words_nxt;
  logic [WIN_W-1:0]  errs_nxt;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign out_data  = head[DATA_W-1:0];
  assign out_err   = err_class_t'(head[FIFO_W-1:DATA_W]);

  always_comb begin
    in_class  = classify(in_syndrome);
    is_err    = (in_class != ERR_NONE);
    words_nxt = win_words + 1'b1;
    errs_nxt  = win_errs + WIN_W'(is_err);
  end

  hamming_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .pop     (out_valid && out_ready),
    .wr_data ({in_class, in_data}),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  // The alarm looks at the post-accept error count so the word that closes a
  // window can still trip it before the window state is zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_count   <= '0;
      uncorr_count <= '0;
      win_words    <= '0;
      win_errs     <= '0;
      alarm        <= 1'b0;
    end else if (clr_stats) begin
      corr_count   <= '0;
      uncorr_count <= '0;
      win_words    <= '0;
      win_errs     <= '0;
      alarm        <= 1'b0;
    end else if (accept) begin
      if (in_class == ERR_CORR && corr_count != '1)
        corr_count <= corr_count + 1'b1;
      if (in_class == ERR_UNCORR && uncorr_count != '1)
        uncorr_count <= uncorr_count + 1'b1;
      if (errs_nxt >= WIN_W'(ALARM_THRESH))
        alarm <= 1'b1;
      if (words_nxt == WIN_W'(WINDOW)) begin
        win_words <= '0;
        win_errs  <= '0;
      end else begin
        win_words <= words_nxt;
        win_errs  <= errs_nxt;
      end
    end
  end

endmodule

// File: tb/tb_hamming_err_monitor.sv
// Directed bench for hamming_err_monitor with a small window and narrow
// counters so alarm and saturation behaviour are reachable quickly.
module tb_hamming_err_monitor;
  import hamming_pkg::*;

  localparam int FIFO_DEPTH   = 4;
  localparam int WINDOW       = 16;
  localparam int ALARM_THRESH = 3;
  localparam int CNT_W        = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [SYN_W-1:0]  in_syndrome = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  err_class_t        out_err;
  logic              clr_stats = 1'b0;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;
  logic              alarm;

  int checks = 0;
  int errors = 0;

  hamming_err_monitor #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .WINDOW       (WINDOW),
    .ALARM_THRESH (ALARM_THRESH),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_syndrome  (in_syndrome),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .clr_stats    (clr_stats),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    clr_stats   = 1'b0;
    in_data     = '0;
    in_syndrome = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Offers one word and holds it until accepted (bounded), ending just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [3:0] syn);
    int waitCycles;
    waitCycles  = 0;
    in_valid    = 1'b1;
    in_data     = data;
    in_syndrome = syn;
    while (!in_ready && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic popWord(input logic [7:0] data, input logic [1:0] err);
    checkOutput("pop_valid", 32'(out_valid), 32'd1);
    checkOutput("pop_data", 32'(out_data), 32'(data));
    checkOutput("pop_err", 32'(out_err), 32'(err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state and in-order classification with a free-running consumer
    doReset();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_corr", 32'(corr_count), 32'd0);
    checkOutput("rst_uncorr", 32'(uncorr_count), 32'd0);
    checkOutput("rst_alarm", 32'(alarm), 32'd0);
    out_ready = 1'b1;
    applyStimulus(8'hA1, 4'd0);
    checkOutput("t1_valid0", 32'(out_valid), 32'd1);
    checkOutput("t1_data0", 32'(out_data), 32'hA1);
    checkOutput("t1_err0", 32'(out_err), 32'd0);
    applyStimulus(8'hA2, 4'd5);
    checkOutput("t1_data1", 32'(out_data), 32'hA2);
    checkOutput("t1_err1", 32'(out_err), 32'd1);
    applyStimulus(8'hA3, 4'd14);
    checkOutput("t1_data2", 32'(out_data), 32'hA3);
    checkOutput("t1_err2", 32'(out_err), 32'd2);
    tick();
    checkOutput("t1_drained", 32'(out_valid), 32'd0);
    checkOutput("t1_corr", 32'(corr_count), 32'd1);
    checkOutput("t1_uncorr", 32'(uncorr_count), 32'd1);
    out_ready = 1'b0;

    // Backpressure: fill, stall the fifth word, free one slot
    doReset();
    applyStimulus(8'hB0, 4'd0);
    applyStimulus(8'hB1, 4'd12);
    applyStimulus(8'hB2, 4'd13);
    applyStimulus(8'hB3, 4'd1);
    checkOutput("t2_full_ready", 32'(in_ready), 32'd0);
    in_valid    = 1'b1;
    in_data     = 8'hB4;
    in_syndrome = 4'd15;
    tick();
    checkOutput("t2_stall_ready", 32'(in_ready), 32'd0);
    checkOutput("t2_hold_data", 32'(out_data), 32'hB0);
    checkOutput("t2_hold_err", 32'(out_err), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t2_slot_free", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("t2_refull", 32'(in_ready), 32'd0);
    popWord(8'hB1, 2'd1);
    popWord(8'hB2, 2'd2);
    popWord(8'hB3, 2'd1);
    popWord(8'hB4, 2'd2);
    checkOutput("t2_empty", 32'(out_valid), 32'd0);

    // Window alarm: 2 errors in a window, then 3 in the next
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      applyStimulus(8'(i), (i == 3 || i == 10) ? 4'd2 : 4'd0);
    checkOutput("t3_win1_alarm", 32'(alarm), 32'd0);
    applyStimulus(8'h20, 4'd9);
    checkOutput("t3_one_err", 32'(alarm), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(8'h21, 4'd0);
    applyStimulus(8'h22, 4'd14);
    checkOutput("t3_two_err", 32'(alarm), 32'd0);
    applyStimulus(8'h23, 4'd6);
    checkOutput("t3_three_err", 32'(alarm), 32'd1);
    for (int i = 0; i < 9; i++) applyStimulus(8'h24, 4'd0);
    checkOutput("t3_sticky", 32'(alarm), 32'd1);

    // Third error lands on the window-closing word
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(8'h30, (i >= 13) ? 4'd4 : 4'd0);
    checkOutput("t3_close_pre", 32'(alarm), 32'd0);
    applyStimulus(8'h31, 4'd4);
    checkOutput("t3_close_alarm", 32'(alarm), 32'd1);

    // Counter saturation at 4 bits
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(8'h40, 4'd3);
    checkOutput("t4_corr15", 32'(corr_count), 32'd15);
    for (int i = 0; i < 5; i++) applyStimulus(8'h41, 4'd3);
    checkOutput("t4_corr_sat", 32'(corr_count), 32'd15);
    checkOutput("t4_uncorr", 32'(uncorr_count), 32'd0);

    // clr_stats coinciding with an accept
    doReset();
    applyStimulus(8'h51, 4'd7);
    applyStimulus(8'h52, 4'd14);
    applyStimulus(8'h53, 4'd7);
    checkOutput("t5_pre_corr", 32'(corr_count), 32'd2);
    checkOutput("t5_pre_uncorr", 32'(uncorr_count), 32'd1);
    checkOutput("t5_pre_alarm", 32'(alarm), 32'd1);
    clr_stats = 1'b1;
    applyStimulus(8'hC5, 4'd7);
    clr_stats = 1'b0;
    checkOutput("t5_clr_corr", 32'(corr_count), 32'd0);
    checkOutput("t5_clr_uncorr", 32'(uncorr_count), 32'd0);
    checkOutput("t5_clr_alarm", 32'(alarm), 32'd0);
    popWord(8'h51, 2'd1);
    popWord(8'h52, 2'd2);
    popWord(8'h53, 2'd1);
    popWord(8'hC5, 2'd1);
    applyStimulus(8'h5A, 4'd7);
    checkOutput("t5_recount", 32'(corr_count), 32'd1);

    // Asynchronous reset with words buffered
    doReset();
    applyStimulus(8'h61, 4'd5);
    applyStimulus(8'h62, 4'd5);
    checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_pre_corr", 32'(corr_count), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_ready", 32'(in_ready), 32'd1);
    checkOutput("t6_corr", 32'(corr_count), 32'd0);
    checkOutput("t6_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("t6_post_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
